// File: rtl/switch_irq_ctrl.sv
// Switch front end for the BitEpicness core: synchronise, debounce, latch, and raise a level IRQ on change.
// Optional `SWITCH_IRQ_MASK_EN adds an IrqMask input that keeps masked bit changes from raising requests.
module switch_irq_ctrl #(
    parameter int unsigned WIDTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic [8:0]  IRQ_VECTOR      = 9'h1F0
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] SwitchRaw,
    input  logic             irq_enable,
    input  logic             irq_ack,
`ifdef SWITCH_IRQ_MASK_EN
    input  logic [WIDTH-1:0] IrqMask,
`endif
    output logic [WIDTH-1:0] SwitchValue,
    output logic             interuptOccurs,
    output logic [8:0]       IrqVector,
    output logic             Overrun
);

    localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_PRE = CNT_W'(DEBOUNCE_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    logic [WIDTH-1:0] sync_meta;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] candidate;
    logic [CNT_W-1:0] count;
    logic             primed;
    logic             pending;
    logic             pending_next;
    logic             overrun_next;
    logic             settle;
    logic             accept;
    logic             irq_change;
    state_t           state;
    state_t           state_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            sync_meta <= '0;
            sync      <= '0;
        end else begin
            sync_meta <= SwitchRaw;
            sync      <= sync_meta;
        end
    end

    // Counter saturates at CNT_MAX; a new sample restarts the stability window.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            candidate <= '0;
            count     <= '0;
        end else if (sync != candidate) begin
            candidate <= sync;
            count     <= '0;
        end else if (count < CNT_MAX) begin
            count <= count + CNT_W'(1);
        end
    end

    // Settle fires on the same edge the counter steps into its saturated value.
    assign settle = (sync == candidate) && (count == CNT_PRE);
    assign accept = settle && primed && (candidate != SwitchValue);

`ifdef SWITCH_IRQ_MASK_EN
    assign irq_change = accept && (((candidate ^ SwitchValue) & ~IrqMask) != '0);
`else
    assign irq_change = accept;
`endif

    // The first settle after reset is a silent priming load, even when the value is zero.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            SwitchValue <= '0;
            primed      <= 1'b0;
        end else if (settle) begin
            primed <= 1'b1;
            if (!primed || (candidate != SwitchValue)) begin
                SwitchValue <= candidate;
            end
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state   <= IDLE;
            pending <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            Overrun <= overrun_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        pending_next = pending | irq_change;
        overrun_next = Overrun;
        unique case (state)
            IDLE: begin
                if (pending && irq_enable) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (irq_ack) begin
                    state_next   = GAP;
                    pending_next = irq_change;
                    if (!accept) begin
                        overrun_next = 1'b0;
                    end
                end else if (irq_change) begin
                    overrun_next = 1'b1;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request level is not gated by irq_enable once raised; GAP forces one low cycle between requests.
    assign interuptOccurs = (state == REQ);
    assign IrqVector      = (state == REQ) ? IRQ_VECTOR : 9'h000;

endmodule

// File: tb/tb_switch_irq_ctrl.sv
// Self-checking bench for switch_irq_ctrl: directed scenarios, then randomized stimulus against a reference model.
// The model describes debounce as "D consecutive equal synchronised samples" over a sample history.
module tb_switch_irq_ctrl;

    localparam int         D   = 4;
    localparam logic [8:0] VEC = 9'h1F0;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] raw;
    logic       en;
    logic       ack;
    logic [7:0] value;
    logic       irq;
    logic [8:0] vec;
    logic       ovr;
`ifdef SWITCH_IRQ_MASK_EN
    logic [7:0] mask;
`endif

    always #5 clk = ~clk;

    switch_irq_ctrl #(
        .WIDTH(8),
        .DEBOUNCE_CYCLES(D),
        .IRQ_VECTOR(VEC)
    ) dut (
        .clk(clk),
        .Reset(rst),
        .SwitchRaw(raw),
        .irq_enable(en),
        .irq_ack(ack),
`ifdef SWITCH_IRQ_MASK_EN
        .IrqMask(mask),
`endif
        .SwitchValue(value),
        .interuptOccurs(irq),
        .IrqVector(vec),
        .Overrun(ovr)
    );

    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state.
    logic [7:0] m_pipe [2];
    logic [7:0] m_hist [$];
    logic [7:0] m_value;
    bit         m_primed;
    bit         m_pending;
    bit         m_req;
    bit         m_gap;
    bit         m_overrun;

    task automatic model_reset();
        m_pipe[0] = 8'h00;
        m_pipe[1] = 8'h00;
        m_hist    = {8'h00};  // debouncer starts as if 0 had already been seen once
        m_value   = 8'h00;
        m_primed  = 0;
        m_pending = 0;
        m_req     = 0;
        m_gap     = 0;
        m_overrun = 0;
    endtask

    task automatic model_edge();
        logic [7:0] seen;
        logic [7:0] msk;
        bit         settled;
        bit         acc;
        bit         acc_irq;
        bit         run;
        int         n;
        msk = 8'h00;
`ifdef SWITCH_IRQ_MASK_EN
        msk = mask;
`endif
        seen      = m_pipe[1];
        m_pipe[1] = m_pipe[0];
        m_pipe[0] = raw;
        m_hist.push_back(seen);
        if (m_hist.size() > D + 1) void'(m_hist.pop_front());
        n       = m_hist.size();
        settled = 0;
        if (n >= D) begin
            run = 1;
            for (int i = 0; i < D; i++) if (m_hist[n-1-i] != seen) run = 0;
            if (run && (n == D || m_hist[n-1-D] != seen)) settled = 1;
        end
        acc     = 0;
        acc_irq = 0;
        if (settled) begin
            if (!m_primed) begin
                m_primed = 1;
                m_value  = seen;
            end else if (seen != m_value) begin
                acc     = 1;
                acc_irq = (((seen ^ m_value) & ~msk) != 8'h00);
                m_value = seen;
            end
        end
        if (m_req) begin
            if (ack) begin
                m_req     = 0;
                m_gap     = 1;
                m_pending = acc_irq;
                if (!acc) m_overrun = 0;
            end else if (acc_irq) begin
                m_overrun = 1;
            end
        end else if (m_gap) begin
            m_gap     = 0;
            m_pending = m_pending | acc_irq;
        end else begin
            if (m_pending && en) m_req = 1;
            m_pending = m_pending | acc_irq;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".value"}, 32'(value), 32'(m_value));
        check({tag, ".irq"},   32'(irq),   32'(m_req));
        check({tag, ".vec"},   32'(vec),   m_req ? 32'(VEC) : 32'd0);
        check({tag, ".ovr"},   32'(ovr),   32'(m_overrun));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        check_all("cyc");
    endtask

    int   rises;
    logic prev;

    initial begin
        rst = 1'b1;
        raw = 8'h04;
        en  = 1'b0;
        ack = 1'b0;
`ifdef SWITCH_IRQ_MASK_EN
        mask = 8'h00;
`endif
        model_reset();
        repeat (3) tick();
        check("reset_value", 32'(value), 32'h00);
        check("reset_irq",   32'(irq),   32'h0);
        check("reset_vec",   32'(vec),   32'h000);
        check("reset_ovr",   32'(ovr),   32'h0);

        // Priming: value held through reset release loads silently at edge 6.
        rst = 1'b0;
        repeat (5) tick();
        check("prime_before", 32'(value), 32'h00);
        tick();
        check("prime_value", 32'(value), 32'h04);
        repeat (4) tick();
        check("prime_quiet", 32'(irq), 32'h0);

        // Single change: value at k+6, request at k+7, cleared by ack.
        en  = 1'b1;
        raw = 8'h05;
        repeat (5) tick();
        check("chg_old", 32'(value), 32'h04);
        tick();
        check("chg_value", 32'(value), 32'h05);
        check("chg_irq_early", 32'(irq), 32'h0);
        tick();
        check("chg_irq", 32'(irq), 32'h1);
        check("chg_vec", 32'(vec), 32'h1F0);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ack_irq", 32'(irq), 32'h0);
        check("ack_vec", 32'(vec), 32'h000);
        repeat (4) tick();

        // Bounce with 2-cycle segments never settles; the final hold gives exactly one request.
        for (int s = 0; s < 10; s++) begin
            raw = (s % 2 == 0) ? 8'h07 : 8'h05;
            repeat (2) begin
                tick();
                check("bounce_value", 32'(value), 32'h05);
            end
        end
        raw   = 8'h07;
        rises = 0;
        prev  = irq;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 5) check("settle_old", 32'(value), 32'h05);
            if (i == 6) check("settle_value", 32'(value), 32'h07);
            if (i == 7) check("settle_irq", 32'(irq), 32'h1);
            if (irq && !prev) rises++;
            prev = irq;
        end
        check("bounce_one_req", 32'(rises), 32'd1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        repeat (3) tick();

        // Two changes without ack: overrun, newest value, single held request.
        raw = 8'h0F;
        repeat (7) tick();
        check("ovr_req", 32'(irq), 32'h1);
        raw = 8'h1F;
        repeat (6) tick();
        check("ovr_value", 32'(value), 32'h1F);
        check("ovr_set", 32'(ovr), 32'h1);
        check("ovr_irq_held", 32'(irq), 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("ovr_cleared", 32'(ovr), 32'h0);
        check("ovr_irq_clr", 32'(irq), 32'h0);
        repeat (3) tick();

        // Accept coincident with ack: 1,0,0,1 and no overrun.
        raw = 8'h3F;
        repeat (7) tick();
        check("coin_req", 32'(irq), 32'h1);
        raw = 8'h7F;
        repeat (5) tick();
        check("coin_pre", 32'(irq), 32'h1);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("coin_c1", 32'(irq), 32'h0);
        check("coin_value", 32'(value), 32'h7F);
        tick();
        check("coin_c2", 32'(irq), 32'h0);
        tick();
        check("coin_c3", 32'(irq), 32'h1);
        check("coin_ovr", 32'(ovr), 32'h0);

        // Reset mid-request clears outputs before the next edge; next stable value primes silently.
        raw = 8'hFF;
        repeat (6) tick();
        check("rst_pre_ovr", 32'(ovr), 32'h1);
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_irq",   32'(irq),   32'h0);
        check("rst_async_value", 32'(value), 32'h00);
        check("rst_async_ovr",   32'(ovr),   32'h0);
        check("rst_async_vec",   32'(vec),   32'h000);
        repeat (2) tick();
        rst = 1'b0;
        repeat (8) tick();
        check("reprime_value", 32'(value), 32'hFF);
        check("reprime_irq", 32'(irq), 32'h0);

        // Randomized stimulus against the model.
        for (int seg = 0; seg < 500; seg++) begin
            int hold;
            if ($urandom_range(0, 3) == 0) raw = 8'($urandom);
            else                           raw = raw ^ 8'(1 << $urandom_range(0, 7));
`ifdef SWITCH_IRQ_MASK_EN
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
`endif
            hold = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 10));
            for (int h = 0; h < hold; h++) begin
                en  = ($urandom_range(0, 9) != 0);
                ack = ($urandom_range(0, 5) == 0);
                tick();
            end
            ack = 1'b0;
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                check_all("rnd_rst");
                tick();
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
